// File: rtl/ccu_snoop_dispatch.sv
// Snoop-path gate between the CCU and the cores. An AC snoop is held back while it
// overlaps the core's in-flight write, and only one snoop per port is outstanding.
package ccu_snoop_pkg;
  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
  } aw_chan_t;

  typedef struct packed {
    logic     aw_valid;
    aw_chan_t aw;
    logic     b_ready;
  } ace_req_t;

  typedef struct packed {
    logic aw_ready;
    logic b_valid;
  } ace_resp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } ace_snoop_req_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } ace_snoop_resp_t;
endpackage

module ccu_snoop_dispatch #(
  parameter int unsigned NoPorts        = 2,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned CachelineWidth = 128,
  parameter type req_t        = ccu_snoop_pkg::ace_req_t,
  parameter type resp_t       = ccu_snoop_pkg::ace_resp_t,
  parameter type snoop_req_t  = ccu_snoop_pkg::ace_snoop_req_t,
  parameter type snoop_resp_t = ccu_snoop_pkg::ace_snoop_resp_t
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  req_t               core_req_i        [NoPorts],
  input  resp_t              core_resp_i       [NoPorts],
  input  snoop_req_t         ccu_snoop_req_i   [NoPorts],
  output snoop_resp_t        ccu_snoop_resp_o  [NoPorts],
  output snoop_req_t         core_snoop_req_o  [NoPorts],
  input  snoop_resp_t        core_snoop_resp_i [NoPorts],
  output logic [NoPorts-1:0] busy_o,
  output logic [15:0]        stall_cnt_o       [NoPorts]
);

  localparam int unsigned AW        = AxiAddrWidth;
  localparam int unsigned LineBytes = CachelineWidth / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AC_PEND = 2'd1,
    WAIT_CR = 2'd2,
    WAIT_CD = 2'd3
  } state_e;

  for (genvar gi = 0; gi < NoPorts; gi++) begin : g_port
    state_e          state_reg, state_next;
    logic            cd_done_reg, cd_done_next;
    logic            wvalid_reg;
    logic [AW-1:0]   wstart_reg;
    logic [AW:0]     wend_reg;
    logic [15:0]     stall_cnt_reg;

    logic            aw_hs, b_hs, cr_hs, cd_last_hs;
    logic            ac_valid_in, core_ac_ready;
    logic            fwd_ac_valid, ret_ac_ready, stall, block;
    logic [8:0]      beats;
    logic [AW-1:0]   aw_start, ac_line;
    logic [AW:0]     aw_end, line_end;
    snoop_req_t      fwd_req;
    snoop_resp_t     ret_resp;

    assign aw_hs         = core_req_i[gi].aw_valid & core_resp_i[gi].aw_ready;
    assign b_hs          = core_resp_i[gi].b_valid & core_req_i[gi].b_ready;
    assign cr_hs         = core_snoop_resp_i[gi].cr_valid & ccu_snoop_req_i[gi].cr_ready;
    assign cd_last_hs    = core_snoop_resp_i[gi].cd_valid & ccu_snoop_req_i[gi].cd_ready
                         & core_snoop_resp_i[gi].cd.last;
    assign ac_valid_in   = ccu_snoop_req_i[gi].ac_valid;
    assign core_ac_ready = core_snoop_resp_i[gi].ac_ready;

    // Window end is one bit wider so a burst ending at the top of memory does not wrap.
    assign beats    = {1'b0, core_req_i[gi].aw.len} + 9'd1;
    assign aw_start = core_req_i[gi].aw.addr[AW-1:0]
                    & ~((AW'(1) << core_req_i[gi].aw.size) - AW'(1));
    assign aw_end   = {1'b0, aw_start} + ((AW+1)'(beats) << core_req_i[gi].aw.size);

    assign ac_line  = ccu_snoop_req_i[gi].ac.addr[AW-1:0] & ~AW'(LineBytes - 1);
    assign line_end = {1'b0, ac_line} + (AW+1)'(LineBytes);
    assign block    = wvalid_reg & ({1'b0, ac_line} < wend_reg)
                    & ({1'b0, wstart_reg} < line_end);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wvalid_reg <= 1'b0;
        wstart_reg <= '0;
        wend_reg   <= '0;
      end else if (aw_hs) begin
        wvalid_reg <= 1'b1;
        wstart_reg <= aw_start;
        wend_reg   <= aw_end;
      end else if (b_hs) begin
        wvalid_reg <= 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_reg     <= IDLE;
        cd_done_reg   <= 1'b0;
        stall_cnt_reg <= '0;
      end else begin
        state_reg   <= state_next;
        cd_done_reg <= cd_done_next;
        if (stall && stall_cnt_reg != 16'hFFFF) begin
          stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
      end
    end

    always_comb begin
      state_next   = state_reg;
      cd_done_next = cd_done_reg;
      fwd_ac_valid = 1'b0;
      ret_ac_ready = 1'b0;
      stall        = 1'b0;
      case (state_reg)
        IDLE: begin
          fwd_ac_valid = ac_valid_in & ~block;
          ret_ac_ready = core_ac_ready & ~block;
          stall        = ac_valid_in & block;
          if (fwd_ac_valid) begin
            state_next = core_ac_ready ? WAIT_CR : AC_PEND;
          end
        end
        // Once offered to the core the snoop stays valid, even if a write window opens.
        AC_PEND: begin
          fwd_ac_valid = ac_valid_in;
          ret_ac_ready = core_ac_ready;
          if (ac_valid_in && core_ac_ready) begin
            state_next = WAIT_CR;
          end
        end
        WAIT_CR: begin
          if (cd_last_hs) begin
            cd_done_next = 1'b1;
          end
          if (cr_hs) begin
            if (core_snoop_resp_i[gi].cr_resp[0] && !cd_done_reg && !cd_last_hs) begin
              state_next = WAIT_CD;
            end else begin
              state_next   = IDLE;
              cd_done_next = 1'b0;
            end
          end
        end
        WAIT_CD: begin
          if (cd_last_hs) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    always_comb begin
      fwd_req           = ccu_snoop_req_i[gi];
      fwd_req.ac_valid  = fwd_ac_valid;
      ret_resp          = core_snoop_resp_i[gi];
      ret_resp.ac_ready = ret_ac_ready;
    end

    assign core_snoop_req_o[gi] = fwd_req;
    assign ccu_snoop_resp_o[gi] = ret_resp;
    assign busy_o[gi]           = (state_reg != IDLE);
    assign stall_cnt_o[gi]      = stall_cnt_reg;

    // A core keeps at most one write in flight.
    a_single_write : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(aw_hs && wvalid_reg && !b_hs));
  end

endmodule

// File: tb/tb_ccu_snoop_dispatch.sv
// Directed bench for ccu_snoop_dispatch: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_ccu_snoop_dispatch;
  import ccu_snoop_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  ace_req_t        core_req   [2];
  ace_resp_t       core_resp  [2];
  ace_snoop_req_t  ccu_sreq   [2];
  ace_snoop_resp_t ccu_sresp  [2];
  ace_snoop_req_t  core_sreq  [2];
  ace_snoop_resp_t core_sresp [2];
  logic [1:0]      busy;
  logic [15:0]     stall [2];

  int checks = 0;
  int errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  ccu_snoop_dispatch dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .core_req_i        (core_req),
    .core_resp_i       (core_resp),
    .ccu_snoop_req_i   (ccu_sreq),
    .ccu_snoop_resp_o  (ccu_sresp),
    .core_snoop_req_o  (core_sreq),
    .core_snoop_resp_i (core_sresp),
    .busy_o            (busy),
    .stall_cnt_o       (stall)
  );

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_v(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ac(input int p, input logic v, input logic [63:0] a);
    ccu_sreq[p].ac_valid = v;
    ccu_sreq[p].ac.addr  = a;
  endtask

  task automatic aw_hs(input int p, input logic [63:0] a, input logic [2:0] sz, input logic [7:0] ln);
    core_req[p].aw_valid  = 1'b1;
    core_req[p].aw.addr   = a;
    core_req[p].aw.size   = sz;
    core_req[p].aw.len    = ln;
    core_resp[p].aw_ready = 1'b1;
    step();
    core_req[p].aw_valid  = 1'b0;
    core_resp[p].aw_ready = 1'b0;
  endtask

  task automatic b_hs(input int p);
    core_resp[p].b_valid = 1'b1;
    core_req[p].b_ready  = 1'b1;
    step();
    core_resp[p].b_valid = 1'b0;
    core_req[p].b_ready  = 1'b0;
  endtask

  task automatic cr_hs(input int p, input logic [4:0] resp);
    core_sresp[p].cr_valid = 1'b1;
    core_sresp[p].cr_resp  = resp;
    ccu_sreq[p].cr_ready   = 1'b1;
    step();
    core_sresp[p].cr_valid = 1'b0;
    ccu_sreq[p].cr_ready   = 1'b0;
  endtask

  task automatic cd_beat(input int p, input logic last);
    core_sresp[p].cd_valid = 1'b1;
    core_sresp[p].cd.last  = last;
    ccu_sreq[p].cd_ready   = 1'b1;
    step();
    core_sresp[p].cd_valid = 1'b0;
    core_sresp[p].cd.last  = 1'b0;
    ccu_sreq[p].cd_ready   = 1'b0;
  endtask

  task automatic start_snoop(input int p, input logic [63:0] a);
    core_sresp[p].ac_ready = 1'b1;
    set_ac(p, 1'b1, a);
    step();
    set_ac(p, 1'b0, 64'h0);
  endtask

  initial begin
    rst_ni = 1'b0;
    for (int p = 0; p < 2; p++) begin
      core_req[p]   = '0;
      core_resp[p]  = '0;
      ccu_sreq[p]   = '0;
      core_sresp[p] = '0;
    end
    set_ac(1, 1'b1, 64'h1008);

    // Reset state: counters/busy clear, forwarded valid follows the input.
    #12;
    expect_v("rst_busy", 32'h0);
    expect_v("rst_stall0", 32'h0);
    expect_v("rst_fwd0", 32'h0);
    expect_v("rst_fwd1", 32'h1);
    check_v(32'(busy));
    check_v(32'(stall[0]));
    check_v(32'(core_sreq[0].ac_valid));
    check_v(32'(core_sreq[1].ac_valid));
    set_ac(1, 1'b0, 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Unblocked snoop, then one-outstanding behaviour in WAIT_CR.
    core_sresp[0].ac_ready = 1'b1;
    set_ac(0, 1'b1, 64'h1008);
    expect_v("unblk_fwd", 32'h1);
    expect_v("unblk_rdy", 32'h1);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    check_v(32'(ccu_sresp[0].ac_ready));
    step();
    set_ac(0, 1'b1, 64'h2000);
    expect_v("waitcr_busy", 32'h1);
    expect_v("second_ac_fwd", 32'h0);
    expect_v("second_ac_rdy", 32'h0);
    #1;
    check_v(32'(busy[0]));
    check_v(32'(core_sreq[0].ac_valid));
    check_v(32'(ccu_sresp[0].ac_ready));
    core_sresp[0].cr_valid = 1'b1;
    core_sresp[0].cr_resp  = 5'd0;
    ccu_sreq[0].cr_ready   = 1'b1;
    expect_v("cr_pass", 32'h1);
    #1;
    check_v(32'(ccu_sresp[0].cr_valid));
    step();
    core_sresp[0].cr_valid = 1'b0;
    ccu_sreq[0].cr_ready   = 1'b0;
    expect_v("idle_busy", 32'h0);
    expect_v("second_ac_fwd_idle", 32'h1);
    #1;
    check_v(32'(busy[0]));
    check_v(32'(core_sreq[0].ac_valid));
    step();
    set_ac(0, 1'b0, 64'h0);
    cr_hs(0, 5'd0);

    // Overlap block: window [0x1000,0x1010); B in the fifth blocked cycle.
    aw_hs(0, 64'h1000, 3'd3, 8'd1);
    set_ac(0, 1'b1, 64'h1008);
    set_ac(1, 1'b1, 64'h1008);
    expect_v("blk_fwd", 32'h0);
    expect_v("blk_rdy", 32'h0);
    expect_v("port1_indep_fwd", 32'h1);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    check_v(32'(ccu_sresp[0].ac_ready));
    check_v(32'(core_sreq[1].ac_valid));
    set_ac(1, 1'b0, 64'h0);
    repeat (4) step();
    core_resp[0].b_valid = 1'b1;
    core_req[0].b_ready  = 1'b1;
    expect_v("blk_b_cycle_fwd", 32'h0);
    expect_v("stall_4", 32'd4);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    check_v(32'(stall[0]));
    step();
    core_resp[0].b_valid = 1'b0;
    core_req[0].b_ready  = 1'b0;
    expect_v("after_b_fwd", 32'h1);
    expect_v("stall_5", 32'd5);
    expect_v("stall1_zero", 32'd0);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    check_v(32'(stall[0]));
    check_v(32'(stall[1]));
    step();
    set_ac(0, 1'b0, 64'h0);
    cr_hs(0, 5'd0);

    // Half-open interval edges, checked combinationally within one cycle.
    aw_hs(0, 64'h1000, 3'd3, 8'd1);
    set_ac(0, 1'b1, 64'h1010);
    expect_v("edge_hi_fwd", 32'h1);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    set_ac(0, 1'b1, 64'h0FF8);
    expect_v("edge_lo_fwd", 32'h1);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    set_ac(0, 1'b1, 64'h100C);
    expect_v("inside_fwd", 32'h0);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    set_ac(0, 1'b0, 64'h0);
    b_hs(0);

    // Unaligned AW: addr 0x2017 size 4 len 3 -> [0x2010,0x2050).
    aw_hs(0, 64'h2017, 3'd4, 8'd3);
    set_ac(0, 1'b1, 64'h2048);
    expect_v("wide_in_fwd", 32'h0);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    set_ac(0, 1'b1, 64'h2050);
    expect_v("wide_end_fwd", 32'h1);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    set_ac(0, 1'b0, 64'h0);
    b_hs(0);

    // Committed AC: forwarded with ready low as an AW to the same line lands.
    core_sresp[0].ac_ready = 1'b0;
    set_ac(0, 1'b1, 64'h1000);
    core_req[0].aw_valid  = 1'b1;
    core_req[0].aw.addr   = 64'h1000;
    core_req[0].aw.size   = 3'd3;
    core_req[0].aw.len    = 8'd0;
    core_resp[0].aw_ready = 1'b1;
    expect_v("same_cycle_aw_fwd", 32'h1);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    step();
    core_req[0].aw_valid  = 1'b0;
    core_resp[0].aw_ready = 1'b0;
    expect_v("acpend_fwd", 32'h1);
    expect_v("acpend_busy", 32'h1);
    expect_v("acpend_rdy", 32'h0);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    check_v(32'(busy[0]));
    check_v(32'(ccu_sresp[0].ac_ready));
    step();
    core_sresp[0].ac_ready = 1'b1;
    expect_v("acpend_fwd2", 32'h1);
    expect_v("acpend_rdy2", 32'h1);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    check_v(32'(ccu_sresp[0].ac_ready));
    step();
    set_ac(0, 1'b0, 64'h0);
    expect_v("acpend_to_waitcr", 32'h1);
    #1;
    check_v(32'(busy[0]));
    b_hs(0);
    cr_hs(0, 5'd0);
    expect_v("acpend_done", 32'h0);
    #1;
    check_v(32'(busy[0]));

    // Data snoop: CR DataTransfer then two CD beats.
    start_snoop(0, 64'h3000);
    cr_hs(0, 5'd1);
    expect_v("data_waitcd", 32'h1);
    #1;
    check_v(32'(busy[0]));
    cd_beat(0, 1'b0);
    expect_v("data_beat1_busy", 32'h1);
    #1;
    check_v(32'(busy[0]));
    core_sresp[0].cd_valid = 1'b1;
    core_sresp[0].cd.last  = 1'b1;
    ccu_sreq[0].cd_ready   = 1'b1;
    expect_v("cd_last_pass", 32'h1);
    #1;
    check_v(32'(ccu_sresp[0].cd.last));
    step();
    core_sresp[0].cd_valid = 1'b0;
    core_sresp[0].cd.last  = 1'b0;
    ccu_sreq[0].cd_ready   = 1'b0;
    expect_v("data_done", 32'h0);
    #1;
    check_v(32'(busy[0]));

    // CD last before CR.
    start_snoop(0, 64'h3000);
    cd_beat(0, 1'b1);
    expect_v("cd_first_busy", 32'h1);
    #1;
    check_v(32'(busy[0]));
    cr_hs(0, 5'd1);
    expect_v("cd_first_done", 32'h0);
    #1;
    check_v(32'(busy[0]));

    // cd_done must have cleared: a fresh data CR waits for CD again.
    start_snoop(0, 64'h3000);
    cr_hs(0, 5'd1);
    expect_v("cd_done_cleared", 32'h1);
    #1;
    check_v(32'(busy[0]));
    cd_beat(0, 1'b1);

    // CR and CD last together; a new AC is held that cycle and forwarded the next.
    start_snoop(0, 64'h3000);
    core_sresp[0].cr_valid = 1'b1;
    core_sresp[0].cr_resp  = 5'd1;
    ccu_sreq[0].cr_ready   = 1'b1;
    core_sresp[0].cd_valid = 1'b1;
    core_sresp[0].cd.last  = 1'b1;
    ccu_sreq[0].cd_ready   = 1'b1;
    set_ac(0, 1'b1, 64'h4000);
    expect_v("close_cycle_fwd", 32'h0);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    step();
    core_sresp[0].cr_valid = 1'b0;
    ccu_sreq[0].cr_ready   = 1'b0;
    core_sresp[0].cd_valid = 1'b0;
    core_sresp[0].cd.last  = 1'b0;
    ccu_sreq[0].cd_ready   = 1'b0;
    expect_v("both_done_busy", 32'h0);
    expect_v("next_ac_fwd", 32'h1);
    #1;
    check_v(32'(busy[0]));
    check_v(32'(core_sreq[0].ac_valid));
    step();
    set_ac(0, 1'b0, 64'h0);
    cr_hs(0, 5'd0);

    // Saturation of the stall counter.
    aw_hs(0, 64'h1000, 3'd3, 8'd1);
    set_ac(0, 1'b1, 64'h1008);
    repeat (100) step();
    expect_v("stall_105", 32'd105);
    check_v(32'(stall[0]));
    repeat (70000) step();
    expect_v("stall_sat", 32'hFFFF);
    check_v(32'(stall[0]));
    b_hs(0);
    step();
    set_ac(0, 1'b0, 64'h0);
    cr_hs(0, 5'd1);
    aw_hs(0, 64'h1000, 3'd3, 8'd0);
    set_ac(0, 1'b1, 64'h1008);
    expect_v("waitcd_busy", 32'h1);
    expect_v("waitcd_fwd", 32'h0);
    #1;
    check_v(32'(busy[0]));
    check_v(32'(core_sreq[0].ac_valid));

    // Asynchronous reset mid-WAIT_CD with a write window open.
    rst_ni = 1'b0;
    expect_v("arst_busy", 32'h0);
    expect_v("arst_stall", 32'h0);
    expect_v("arst_fwd", 32'h1);
    #1;
    check_v(32'(busy));
    check_v(32'(stall[0]));
    check_v(32'(core_sreq[0].ac_valid));
    @(negedge clk_i);
    rst_ni = 1'b1;
    expect_v("post_rst_fwd", 32'h1);
    #1;
    check_v(32'(core_sreq[0].ac_valid));
    set_ac(0, 1'b0, 64'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
